// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb_rv32 arbiter: FSM encoding and default sizing.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_NCH = 2;
   localparam int DEF_AW  = 32;
   localparam int DEF_DW  = 32;
   localparam int DEF_TMO = 255;
endpackage

// File: rtl/mem_arb_rv32_rr_pick.sv
// Round-robin picker: first requesting channel strictly after last_i, wrapping modulo NCH.
module rr_pick_rv32 #(
   parameter int NCH = 2,
   parameter int IW  = 1
) (
   input  logic [NCH-1:0] req_i,
   input  logic [IW-1:0]  last_i,
   output logic [IW-1:0]  idx_o,
   output logic           vld_o
);
   int c;

   // Walk farthest-to-nearest so the nearest requester after last_i wins.
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      c     = 0;
      for (int i = NCH; i >= 1; i--) begin
         c = (int'(last_i) + i) % NCH;
         if (req_i[c]) begin
            idx_o = IW'(c);
            vld_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_arb_rv32.sv
// N-channel round-robin arbiter onto a single backing-memory port (IDLE -> BUS -> RESP).
// Optional bus timeout enabled by defining MEM_ARB_TMO_EN.
module mem_arb_rv32
   import mem_arb_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int AW  = DEF_AW,
   parameter int DW  = DEF_DW,
   parameter int TMO = DEF_TMO
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [NCH-1:0]    iREQ,
   input  logic [NCH-1:0]    iWE,
   input  logic [NCH*AW-1:0] iADDR,
   input  logic [NCH*DW-1:0] iWDATA,
   output logic [NCH-1:0]    oACK,
   output logic [DW-1:0]     oRDATA,
   output logic [NCH-1:0]    oERR,
   output logic              oBUSY,
   output logic              oMEM_REQ,
   output logic              oMEM_WE,
   output logic [AW-1:0]     oMEM_ADDR,
   output logic [DW-1:0]     oMEM_WDATA,
   input  logic              iMEM_RDY,
   input  logic [DW-1:0]     iMEM_RDATA
);
   localparam int IW = $clog2(NCH);

   state_e          state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   gnt_q, gnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [IW-1:0]   pick_idx;
   logic            pick_vld;
   logic            tmo_hit;
   logic [NCH-1:0]  gnt_oh;

   rr_pick_rv32 #(.NCH(NCH), .IW(IW)) u_pick (
      .req_i  (iREQ),
      .last_i (last_q),
      .idx_o  (pick_idx),
      .vld_o  (pick_vld)
   );

`ifdef MEM_ARB_TMO_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign tmo_hit = (state_q == ST_BUS) && !iMEM_RDY && (cnt_q == CW'(TMO - 1));
   assign cnt_d   = (state_q == ST_BUS) ? cnt_q + 1'b1 : '0;
   // Error flag is set only on a timeout exit from BUS and held through RESP.
   assign err_d   = (state_q == ST_BUS) ? tmo_hit : (state_q == ST_RESP) ? err_q : 1'b0;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign oERR = (state_q == ST_RESP && err_q) ? gnt_oh : '0;
`else
   assign tmo_hit = 1'b0;
   assign oERR    = '0;
`endif

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= ST_IDLE;
         last_q  <= IW'(NCH - 1);
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick_idx;
               we_d    = iWE[pick_idx];
               addr_d  = iADDR[int'(pick_idx)*AW +: AW];
               wdata_d = iWDATA[int'(pick_idx)*DW +: DW];
               rdata_d = '0;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            // A real completion takes precedence over a timeout in the same cycle.
            if (iMEM_RDY) begin
               rdata_d = we_q ? '0 : iMEM_RDATA;
               state_d = ST_RESP;
            end else if (tmo_hit) begin
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            last_d  = gnt_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_oh        = '0;
      gnt_oh[gnt_q] = 1'b1;
   end

   assign oBUSY      = (state_q != ST_IDLE);
   assign oMEM_REQ   = (state_q == ST_BUS);
   assign oMEM_WE    = oMEM_REQ & we_q;
   assign oMEM_ADDR  = oMEM_REQ ? addr_q : '0;
   assign oMEM_WDATA = oMEM_REQ ? wdata_q : '0;
   assign oACK       = (state_q == ST_RESP) ? gnt_oh : '0;
   assign oRDATA     = (state_q == ST_RESP) ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arb_rv32.sv
// Directed bench for mem_arb_rv32: a 2-channel instance and a 4-channel instance for pointer wrap.
module tb_mem_arb_rv32;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [1:0]  req = '0, we = '0;
   logic [63:0] addr = '0, wdata = '0;
   logic [1:0]  ack, err;
   logic [31:0] rdata, mwdata, maddr, mrdata = '0;
   logic        busy, mreq, mwe, mrdy = 1'b0;

   logic [3:0]  req4 = '0, we4 = '0;
   logic [63:0] addr4 = '0, wdata4 = '0;
   logic [3:0]  ack4, err4;
   logic [15:0] rdata4, mwdata4, maddr4, mrdata4 = '0;
   logic        busy4, mreq4, mwe4, mrdy4 = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arb_rv32 #(.NCH(2), .AW(32), .DW(32), .TMO(4)) dut (
      .iCLK(clk), .iRST(rst_n), .iREQ(req), .iWE(we), .iADDR(addr), .iWDATA(wdata),
      .oACK(ack), .oRDATA(rdata), .oERR(err), .oBUSY(busy),
      .oMEM_REQ(mreq), .oMEM_WE(mwe), .oMEM_ADDR(maddr), .oMEM_WDATA(mwdata),
      .iMEM_RDY(mrdy), .iMEM_RDATA(mrdata)
   );

   mem_arb_rv32 #(.NCH(4), .AW(16), .DW(16), .TMO(4)) dut4 (
      .iCLK(clk), .iRST(rst_n), .iREQ(req4), .iWE(we4), .iADDR(addr4), .iWDATA(wdata4),
      .oACK(ack4), .oRDATA(rdata4), .oERR(err4), .oBUSY(busy4),
      .oMEM_REQ(mreq4), .oMEM_WE(mwe4), .oMEM_ADDR(maddr4), .oMEM_WDATA(mwdata4),
      .iMEM_RDY(mrdy4), .iMEM_RDATA(mrdata4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_ack;

      // Reset state
      step(); step();
      chk("rst_ack",   ack,   0);
      chk("rst_busy",  busy,  0);
      chk("rst_mreq",  mreq,  0);
      chk("rst_maddr", maddr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err",   err,   0);
      chk("rst_ack4",  ack4,  0);
      rst_n = 1'b1;
      step();

      // iMEM_RDY in IDLE with no request is ignored
      mrdy = 1'b1;
      step(); step();
      chk("idle_rdy_busy", busy, 0);
      chk("idle_rdy_ack",  ack,  0);

      // Both channels requesting, iMEM_RDY tied 1: alternating grants every 3 cycles
      addr  = {32'h0000_0204, 32'h0000_0200};
      req   = 2'b11;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c % 3 == 2) exp_ack = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
         else            exp_ack = 2'b00;
         chk($sformatf("rr_ack_c%0d", c), ack, exp_ack);
         if (c == 11) req = 2'b00;
      end
      mrdy = 1'b0;
      step();

      // ch0 read 0x100, RDY at cycle 3 -> ACK at cycle 4
      addr = {32'h0, 32'h0000_0100};
      we   = 2'b00;
      req  = 2'b01;
      step();
      chk("rd_mreq",  mreq,  1);
      chk("rd_maddr", maddr, 32'h100);
      chk("rd_mwe",   mwe,   0);
      chk("rd_busy",  busy,  1);
      step();
      chk("rd_c2_ack",  ack,  0);
      chk("rd_c2_mreq", mreq, 1);
      step();
      mrdy   = 1'b1;
      mrdata = 32'hDEAD_BEEF;
      step();
      chk("rd_c4_ack",   ack,   2'b01);
      chk("rd_c4_rdata", rdata, 32'hDEAD_BEEF);
      chk("rd_c4_mreq",  mreq,  0);
      chk("rd_c4_busy",  busy,  1);
      req    = 2'b00;
      mrdy   = 1'b0;
      mrdata = 32'h0;
      step();
      chk("rd_c5_ack",   ack,   0);
      chk("rd_c5_rdata", rdata, 0);

      // ch1 write 0x20 <= 0x55AA, ch1 drops request after latch, ch0 arrives mid-BUS
      addr   = {32'h0000_0020, 32'h0000_0040};
      wdata  = {32'h0000_55AA, 32'h0000_0000};
      we     = 2'b10;
      req    = 2'b10;
      mrdata = 32'h1234_5678;
      step();
      chk("wr_mwe",    mwe,    1);
      chk("wr_maddr",  maddr,  32'h20);
      chk("wr_mwdata", mwdata, 32'h55AA);
      req = 2'b01;
      step();
      chk("wr_hold_maddr", maddr, 32'h20);
      chk("wr_hold_ack",   ack,   0);
      mrdy = 1'b1;
      step();
      chk("wr_ack1",  ack,   2'b10);
      chk("wr_rdata", rdata, 0);
      mrdy = 1'b0;
      step();
      chk("wr_idle_ack", ack, 0);
      step();
      chk("ch0_after_maddr", maddr, 32'h40);
      chk("ch0_after_mwe",   mwe,   0);
      mrdy   = 1'b1;
      mrdata = 32'hCAFE_F00D;
      step();
      chk("ch0_after_ack",   ack,   2'b01);
      chk("ch0_after_rdata", rdata, 32'hCAFE_F00D);
      req  = 2'b00;
      mrdy = 1'b0;
      step();

      // Reset during BUS aborts ch1; ch0 wins first after release
      addr = {32'h0000_0300, 32'h0000_0100};
      we   = 2'b00;
      req  = 2'b10;
      step();
      chk("abort_pre_maddr", maddr, 32'h300);
      req   = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("abort_mreq_now", mreq, 0);
      step();
      chk("abort_mreq",  mreq,  0);
      chk("abort_busy",  busy,  0);
      chk("abort_ack",   ack,   0);
      chk("abort_maddr", maddr, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_maddr", maddr, 32'h100);
      chk("post_rst_ack",   ack,   0);
      mrdy   = 1'b1;
      mrdata = 32'h0000_0A0A;
      req    = 2'b00;
      step();
      chk("post_rst_ack0", ack, 2'b01);
      mrdy = 1'b0;
      step();

      // Memory never ready: timeout (if built in) or indefinite wait
      addr = {32'h0, 32'h0000_0500};
      req  = 2'b01;
      step();
      chk("tmo_bus", mreq, 1);
      step(); step(); step();
      chk("tmo_c4_ack", ack, 0);
      step();
`ifdef MEM_ARB_TMO_EN
      chk("tmo_ack",   ack,   2'b01);
      chk("tmo_err",   err,   2'b01);
      chk("tmo_rdata", rdata, 0);
      chk("tmo_mreq",  mreq,  0);
      req = 2'b00;
      step();
      chk("tmo_done_err", err, 0);
`else
      chk("notmo_mreq", mreq, 1);
      chk("notmo_ack",  ack,  0);
      chk("notmo_err",  err,  0);
      step(); step(); step();
      chk("notmo_late_mreq", mreq, 1);
      mrdy   = 1'b1;
      mrdata = 32'h0000_7777;
      req    = 2'b00;
      step();
      chk("notmo_ack_done", ack,   2'b01);
      chk("notmo_err_done", err,   0);
      chk("notmo_rdata",    rdata, 32'h7777);
      mrdy = 1'b0;
      step();
`endif

      // 4-channel instance: last_grant=3 after reset, ch1 and ch3 requesting -> ch1 then ch3
      addr4 = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      req4  = 4'b1010;
      mrdy4 = 1'b1;
      step();
      chk("wrap_maddr1", maddr4, 16'h1111);
      step();
      chk("wrap_ack1", ack4, 4'b0010);
      step();
      chk("wrap_idle", ack4, 4'b0000);
      step();
      chk("wrap_maddr3", maddr4, 16'h3333);
      req4 = 4'b0000;
      step();
      chk("wrap_ack3", ack4, 4'b1000);
      mrdy4 = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arb_rv32.md
MEM_ARB_RV32 -- requirements
Module: mem_arb_rv32

Interface
REQ-001 Parameter NCH, default 2, SHALL set the number of requester channels (2..8).
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 Parameter DW, default 32, SHALL set the data width.
REQ-004 Parameter TMO, default 255, SHALL set the timeout limit in cycles (used only with MEM_ARB_TMO_EN).
REQ-005 iCLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 iRST  input  1  reset, asynchronous, active-low.
REQ-007 iREQ  input  NCH  per-channel request, held high until that channel's oACK.
REQ-008 iWE  input  NCH  per-channel access type: 1 = write, 0 = read.
REQ-009 iADDR  input  NCH*AW  packed addresses; channel c occupies bits [c*AW +: AW].
REQ-010 iWDATA  input  NCH*DW  packed write data; channel c occupies bits [c*DW +: DW].
REQ-011 oACK  output  NCH  one-cycle completion pulse per channel.
REQ-012 oRDATA  output  DW  read data, valid only in the oACK cycle.
REQ-013 oERR  output  NCH  timeout flag, coincident with oACK.
REQ-014 oBUSY  output  1  transaction in progress.
REQ-015 oMEM_REQ, oMEM_WE  output  1 each  backing-memory request and direction.
REQ-016 oMEM_ADDR  output  AW; oMEM_WDATA  output  DW  backing-memory address and write data.
REQ-017 iMEM_RDY  input  1; iMEM_RDATA  input  DW  backing-memory completion and read data.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-019 In IDLE with any iREQ bit high, the block SHALL round-robin select channel g, the first requesting channel after last_grant (modulo NCH), latch its iWE/iADDR/iWDATA and move to BUS.
REQ-020 In BUS the block SHALL drive oMEM_REQ=1 from the latched fields, with payload stable until completion.
REQ-021 On iMEM_RDY=1 sampled in BUS, the block SHALL capture iMEM_RDATA, drop oMEM_REQ next cycle and move to RESP.
REQ-022 In RESP the block SHALL pulse oACK[g] for exactly one cycle, drive oRDATA, set last_grant=g and return to IDLE.
REQ-023 Latency: request seen in IDLE at cycle 0 -> oMEM_REQ at cycle 1; iMEM_RDY at cycle k -> oACK at cycle k+1; minimum 3 cycles.
REQ-024 A request arriving in BUS or RESP SHALL wait, with no loss and no reordering among pending channels.
REQ-025 A channel dropping iREQ after being latched SHALL NOT abort the transaction; its oACK SHALL still pulse.
REQ-026 iMEM_RDY outside BUS SHALL be ignored.
REQ-027 oRDATA for write transactions SHALL be 0.
REQ-028 oBUSY SHALL be high in BUS and RESP.
REQ-029 Pointer wrap: with last_grant=NCH-1, the search SHALL start at channel 0.

Reset
REQ-030 Reset low SHALL force IDLE immediately, including mid-transaction, and set last_grant=NCH-1.
REQ-031 Reset low SHALL force all outputs and latched fields to 0; no oACK SHALL be issued for an aborted transaction.

Configuration
REQ-032 With MEM_ARB_TMO_EN defined, a counter SHALL run in BUS; after TMO cycles without iMEM_RDY, the block SHALL go to RESP with oERR[g]=1, oRDATA=0, and oMEM_REQ dropped.
REQ-033 Without MEM_ARB_TMO_EN, no counter SHALL exist, oERR SHALL be tied to 0, and BUS SHALL wait indefinitely.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the FSM state encoding and the default NCH/AW/DW/TMO constants.
REQ-035 Round-robin selection SHALL be a sub-module rr_pick_rv32 (inputs: request vector, last_grant; outputs: index, valid).

Verification
REQ-036 NCH=2; ch0 read 0x100; iMEM_RDY at cycle 3 with RDATA 0xDEADBEEF -> oACK[0] at cycle 4, oRDATA=0xDEADBEEF.
REQ-037 Both channels requesting continuously with iMEM_RDY tied 1 -> grants alternate ch0, ch1, ch0, ch1, one oACK every 3 cycles.
REQ-038 ch1 write 0x20 <= 0x55AA; ch0 requests mid-BUS -> oMEM_WE=1, ADDR=0x20, WDATA=0x55AA; ch1 acked first, then ch0.
REQ-039 iRST low during BUS -> next cycle all outputs 0; ch0 then granted first after reset release.
REQ-040 MEM_ARB_TMO_EN with TMO=4 and iMEM_RDY held 0 -> oACK[g] and oERR[g] high together 4 cycles after BUS entry, oRDATA=0.
REQ-041 NCH=4 with last_grant=3 and channels 1 and 3 requesting -> channel 1 granted (wrap-around).
